// File: rtl/crc_gen_pkg.sv
// ============================================================================
// Module      : crc_gen_pkg
// Description : Shared types and constants for the serial CRC stage
//               (packet types, field lengths, CRC polynomials/residuals,
//               crc_gen state encodings).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crc_gen_pkg;

  // Packet-type encodings shared with the bit-stream encoder
  typedef enum logic [1:0] {
    PKT_NONE   = 2'b00,
    PKT_TOKEN  = 2'b01,
    PKT_HSHAKE = 2'b10,
    PKT_DATA   = 2'b11
  } pkt_type_e;

  // Pass-through field lengths (bits never enter the CRC)
  localparam int SYNC_BITS = 8;
  localparam int PID_BITS  = 8;

  // CRC generators and the residuals a receiver sees over payload+CRC
  localparam int          CRC5_W         = 5;
  localparam int          CRC16_W        = 16;
  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // crc_gen state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SYNC     = 3'd1;
  localparam logic [2:0] ST_PID      = 3'd2;
  localparam logic [2:0] ST_BODY     = 3'd3;
  localparam logic [2:0] ST_APPEND   = 3'd4;
  localparam logic [2:0] ST_WAIT_END = 3'd5;

endpackage

`default_nettype wire

// File: rtl/crc_gen_if.sv
// ============================================================================
// Module      : crc_gen_if
// Description : Serial packet bus between encoder, CRC stage and bit stuffer.
//               master = stream source/sink environment, slave = crc_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crc_gen_if;

  logic [1:0] pkt_in;
  logic       endr;
  logic       s_in;
  logic       s_out;
  logic       s_valid;
  logic       pkt_end;
  logic       busy;

  modport master (
    output pkt_in,
    output endr,
    output s_in,
    input  s_out,
    input  s_valid,
    input  pkt_end,
    input  busy
  );

  modport slave (
    input  pkt_in,
    input  endr,
    input  s_in,
    output s_out,
    output s_valid,
    output pkt_end,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/crc_gen_lfsr.sv
// ============================================================================
// Module      : crc_lfsr
// Description : Serial CRC LFSR, MSB-first feedback, parameterised width and
//               generator polynomial. ld_init reloads the seed, en shifts din.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_lfsr #(
  parameter int           W    = 5,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_init,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic w_fb;

  assign w_fb = din ^ q[W-1];

  // Seed on reload, otherwise shift one bit per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (ld_init) begin
      q <= INIT;
    end else if (en) begin
      q <= {q[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/crc_gen.sv
// ============================================================================
// Module      : crc_gen
// Description : Serial CRC stage. Forwards SYNC/PID/payload with one cycle of
//               latency, computes CRC5 (token) or CRC16 (data) over the
//               payload, appends the complemented CRC MSB first directly after
//               the last payload bit and then pulses pkt_end.
//               Optional build macro: CRC_ERR_INJECT_EN adds input crc_corrupt,
//               which inverts the final appended CRC bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_gen
  import crc_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
`ifdef CRC_ERR_INJECT_EN
  input  logic       crc_corrupt,
`endif
  crc_gen_if.slave   bus
);

  localparam logic [4:0] c_sync_last  = 5'(SYNC_BITS - 1);
  localparam logic [4:0] c_pid_last   = 5'(PID_BITS - 1);
  localparam logic [4:0] c_crc5_last  = 5'(CRC5_W - 1);
  localparam logic [4:0] c_crc16_last = 5'(CRC16_W - 1);

  logic [2:0]  r_state;
  pkt_type_e   r_type;
  logic [4:0]  r_cnt;
  logic        r_s_out;
  logic        r_s_valid;
  logic        r_pkt_end;
  logic        r_wait_first;
  logic        r_corrupt;
  logic [15:0] r_shift;

  logic        w_start;
  logic        w_en5;
  logic        w_en16;
  logic [4:0]  w_crc5;
  logic [15:0] w_crc16;
  logic [15:0] w_crc_out;
  logic        w_append_last;
  logic        w_corrupt;

`ifdef CRC_ERR_INJECT_EN
  assign w_corrupt = crc_corrupt;
`else
  assign w_corrupt = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) && (bus.pkt_in != PKT_NONE);
  assign w_en5   = (r_state == ST_BODY) && !bus.endr && (r_type == PKT_TOKEN);
  assign w_en16  = (r_state == ST_BODY) && !bus.endr && (r_type == PKT_DATA);

  // Complemented CRC left-aligned so both widths shift out of bit 15
  assign w_crc_out = (r_type == PKT_TOKEN) ? {~w_crc5, 11'b0} : ~w_crc16;

  assign w_append_last = (r_type == PKT_TOKEN) ? (r_cnt == c_crc5_last)
                                               : (r_cnt == c_crc16_last);

  crc_lfsr #(
    .W    (CRC5_W),
    .POLY (CRC5_POLY)
  ) u_crc5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_init (w_start),
    .en      (w_en5),
    .din     (bus.s_in),
    .q       (w_crc5)
  );

  crc_lfsr #(
    .W    (CRC16_W),
    .POLY (CRC16_POLY)
  ) u_crc16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_init (w_start),
    .en      (w_en16),
    .din     (bus.s_in),
    .q       (w_crc16)
  );

  // Packet sequencer; all stream outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_type       <= PKT_NONE;
      r_cnt        <= 5'd0;
      r_s_out      <= 1'b0;
      r_s_valid    <= 1'b0;
      r_pkt_end    <= 1'b0;
      r_wait_first <= 1'b0;
      r_corrupt    <= 1'b0;
      r_shift      <= 16'h0;
    end else begin
      // pkt_end trails WAIT_END entry by one cycle so it follows the last bit
      r_pkt_end    <= r_wait_first;
      r_wait_first <= 1'b0;
      r_s_valid    <= 1'b0;
      r_s_out      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_type    <= pkt_type_e'(bus.pkt_in);
            r_cnt     <= 5'd0;
            r_corrupt <= 1'b0;
            r_state   <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (bus.endr) begin
            r_cnt        <= 5'd0;
            r_wait_first <= 1'b1;
            r_state      <= ST_WAIT_END;
          end else begin
            r_s_out   <= bus.s_in;
            r_s_valid <= 1'b1;
            if (r_cnt == c_sync_last) begin
              r_cnt   <= 5'd0;
              r_state <= ST_PID;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        ST_PID: begin
          if (bus.endr) begin
            r_cnt        <= 5'd0;
            r_wait_first <= 1'b1;
            r_state      <= ST_WAIT_END;
          end else begin
            r_s_out   <= bus.s_in;
            r_s_valid <= 1'b1;
            if (r_cnt == c_pid_last) begin
              r_cnt <= 5'd0;
              if (r_type == PKT_HSHAKE) begin
                r_wait_first <= 1'b1;
                r_state      <= ST_WAIT_END;
              end else begin
                r_state <= ST_BODY;
              end
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        ST_BODY: begin
          if (bus.endr) begin
            // First CRC bit leaves now so it abuts the last payload bit
            r_s_out   <= w_crc_out[15];
            r_s_valid <= 1'b1;
            r_shift   <= {w_crc_out[14:0], 1'b0};
            r_cnt     <= 5'd1;
            r_corrupt <= w_corrupt;
            r_state   <= ST_APPEND;
          end else begin
            r_s_out   <= bus.s_in;
            r_s_valid <= 1'b1;
          end
        end
        ST_APPEND: begin
          r_s_valid <= 1'b1;
          r_shift   <= {r_shift[14:0], 1'b0};
          if (w_append_last) begin
            r_s_out      <= r_shift[15] ^ r_corrupt;
            r_cnt        <= 5'd0;
            r_wait_first <= 1'b1;
            r_state      <= ST_WAIT_END;
          end else begin
            r_s_out <= r_shift[15];
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        ST_WAIT_END: begin
          if (!bus.endr) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_out   = r_s_out;
  assign bus.s_valid = r_s_valid;
  assign bus.pkt_end = r_pkt_end;
  assign bus.busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_crc_gen.sv
// ============================================================================
// Module      : tb_crc_gen
// Description : Self-checking bench for crc_gen: table of packet vectors plus
//               hand sequences for mid-packet reset and PID truncation.
//               Build macro CRC_ERR_INJECT_EN adds a corrupted-CRC vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_gen;
  import crc_gen_pkg::*;

  logic clk;
  logic rst_n;
  logic crc_corrupt;

  crc_gen_if bus ();

  crc_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef CRC_ERR_INJECT_EN
    .crc_corrupt (crc_corrupt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ptype;
    logic [7:0]  pid;
    logic [63:0] payload;
    int          nbits;
    int          crc_len;
    logic [15:0] crc_exp;
    int          inj_at;
    logic        endr_start;
    logic        corrupt;
  } vec_t;

  int   total = 0;
  int   bad   = 0;

  // Output monitor, sampled on the falling edge
  logic cap[$];
  int   mon_cyc = 0;
  int   first_v = -1;
  int   last_v  = -1;
  int   pend_n  = 0;
  int   pend_cyc = -1;

  always @(negedge clk) begin
    mon_cyc = mon_cyc + 1;
    if (bus.s_valid === 1'b1) begin
      if (first_v < 0) first_v = mon_cyc;
      last_v = mon_cyc;
      cap.push_back(bus.s_out);
    end
    if (bus.pkt_end === 1'b1) begin
      pend_n   = pend_n + 1;
      pend_cyc = mon_cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cap.delete();
    first_v  = -1;
    last_v   = -1;
    pend_n   = 0;
    pend_cyc = -1;
  endtask

  function automatic logic [15:0] crc16_tx(input logic [63:0] d, input int n);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = d[i] ^ r[15];
      r  = {r[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0);
    end
    return ~r;
  endfunction

  function automatic logic expected_bit(input vec_t v, input int i);
    logic [7:0] sync_pat;
    sync_pat = 8'h80;
    if (i < SYNC_BITS) return sync_pat[i];
    if (i < SYNC_BITS + PID_BITS) return v.pid[i - SYNC_BITS];
    return v.payload[i - SYNC_BITS - PID_BITS];
  endfunction

  task automatic send(input vec_t v);
    logic [7:0] sync_pat;
    sync_pat = 8'h80;
    clear_mon();
    crc_corrupt = v.corrupt;
    bus.pkt_in  = v.ptype;
    bus.endr    = v.endr_start;
    bus.s_in    = 1'b0;
    tick();
    bus.pkt_in = 2'b00;
    bus.endr   = 1'b0;
    for (int i = 0; i < SYNC_BITS; i++) begin
      bus.s_in = sync_pat[i];
      tick();
    end
    for (int i = 0; i < PID_BITS; i++) begin
      bus.s_in = v.pid[i];
      tick();
    end
    for (int i = 0; i < v.nbits; i++) begin
      bus.s_in   = v.payload[i];
      bus.pkt_in = (i == v.inj_at) ? 2'b11 : 2'b00;
      tick();
    end
    bus.pkt_in = 2'b00;
    bus.endr   = 1'b1;
    bus.s_in   = 1'b1;
    repeat (24) tick();
    bus.endr = 1'b0;
    bus.s_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    int          nfwd;
    int          nmis;
    logic [15:0] got;
    logic [15:0] r16;
    logic [4:0]  r5;
    logic        fb;
    nfwd = SYNC_BITS + PID_BITS + v.nbits;
    chk({tag, "_len"}, cap.size(), nfwd + v.crc_len);
    nmis = 0;
    for (int i = 0; i < nfwd && i < cap.size(); i++)
      if (cap[i] !== expected_bit(v, i)) nmis++;
    chk({tag, "_fwd_mismatches"}, nmis, 0);
    got = 16'h0;
    for (int j = 0; j < v.crc_len && (nfwd + j) < cap.size(); j++)
      got = {got[14:0], cap[nfwd + j]};
    if (v.crc_len > 0) chk({tag, "_crc"}, got, v.crc_exp);
    chk({tag, "_contig"}, last_v - first_v + 1, cap.size());
    chk({tag, "_pkt_end_count"}, pend_n, 1);
    chk({tag, "_pkt_end_pos"}, pend_cyc, last_v + 1);
    chk({tag, "_busy_idle"}, bus.busy, 1'b0);
    // Receiver-side residual over payload plus transmitted CRC
    if (v.crc_len > 0 && !v.corrupt) begin
      r16 = 16'hFFFF;
      r5  = 5'h1F;
      for (int i = SYNC_BITS + PID_BITS; i < cap.size(); i++) begin
        if (v.crc_len == 5) begin
          fb = cap[i] ^ r5[4];
          r5 = {r5[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h0);
        end else begin
          fb  = cap[i] ^ r16[15];
          r16 = {r16[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0);
        end
      end
      if (v.crc_len == 5) chk({tag, "_residual"}, r5, CRC5_RESIDUAL);
      else                chk({tag, "_residual"}, r16, CRC16_RESIDUAL);
    end
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [7:0] sync_pat;

    // {type, pid, payload, nbits, crc_len, crc_exp, inj_at, endr_start, corrupt}
    vecs.push_back('{2'b01, 8'h2D, 64'h715, 11, 5, 16'h0017, -1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'hC3, 64'h0, 64, 16, crc16_tx(64'h0, 64), -1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'hC3, 64'h0123456789ABCDEF, 64, 16,
                     crc16_tx(64'h0123456789ABCDEF, 64), -1, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 8'hD2, 64'h0, 0, 0, 16'h0, -1, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 8'h69, 64'h000, 11, 5, 16'h0008, -1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 8'hC3, 64'h0123456789ABCDEF, 64, 16,
                     crc16_tx(64'h0123456789ABCDEF, 64), 20, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 8'h2D, 64'h715, 11, 5, 16'h0017, -1, 1'b1, 1'b0});
`ifdef CRC_ERR_INJECT_EN
    vecs.push_back('{2'b01, 8'h2D, 64'h715, 11, 5, 16'h0016, -1, 1'b0, 1'b1});
`endif

    rst_n       = 1'b0;
    crc_corrupt = 1'b0;
    bus.pkt_in  = 2'b00;
    bus.endr    = 1'b0;
    bus.s_in    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_s_out", bus.s_out, 1'b0);
    chk("reset_s_valid", bus.s_valid, 1'b0);
    chk("reset_pkt_end", bus.pkt_end, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int k = 0; k < vecs.size(); k++) begin
      send(vecs[k]);
      check_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset asserted while the data body is at bit 40
    v = vecs[2];
    sync_pat = 8'h80;
    clear_mon();
    bus.pkt_in = 2'b11;
    tick();
    bus.pkt_in = 2'b00;
    for (int i = 0; i < SYNC_BITS; i++) begin bus.s_in = sync_pat[i]; tick(); end
    for (int i = 0; i < PID_BITS; i++) begin bus.s_in = v.pid[i]; tick(); end
    for (int i = 0; i < 40; i++) begin bus.s_in = v.payload[i]; tick(); end
    bus.s_in = v.payload[40];
    chk("pre_reset_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_s_out", bus.s_out, 1'b0);
    chk("midrst_s_valid", bus.s_valid, 1'b0);
    chk("midrst_pkt_end", bus.pkt_end, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.s_in = 1'b0;
    clear_mon();
    repeat (5) tick();
    chk("midrst_no_tail_bits", cap.size(), 0);
    chk("midrst_no_pkt_end", pend_n, 0);
    send(vecs[0]);
    check_vec(vecs[0], "after_rst");

    // endr raised after 3 PID bits: truncated, no append, pkt_end still pulses
    v = vecs[0];
    clear_mon();
    bus.pkt_in = 2'b01;
    tick();
    bus.pkt_in = 2'b00;
    for (int i = 0; i < SYNC_BITS; i++) begin bus.s_in = sync_pat[i]; tick(); end
    for (int i = 0; i < 3; i++) begin bus.s_in = v.pid[i]; tick(); end
    bus.endr = 1'b1;
    bus.s_in = 1'b1;
    repeat (10) tick();
    chk("trunc_busy_held", bus.busy, 1'b1);
    bus.endr = 1'b0;
    repeat (3) tick();
    chk("trunc_len", cap.size(), SYNC_BITS + 3);
    chk("trunc_pkt_end_count", pend_n, 1);
    chk("trunc_busy_idle", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
